// File: rtl/layer_fc_param_if.sv
// Stream bundle for layer_fc_param: weight and x input streams plus the y output stream.
// The slave modport is the engine's view, the master modport is the producer/consumer view.
interface layer_fc_param_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] s_data_in_w;
    logic                    s_valid_w;
    logic                    s_ready_w;
    logic signed [WIDTH-1:0] s_data_in_x;
    logic                    s_valid_x;
    logic                    s_ready_x;
    logic signed [WIDTH-1:0] m_data_out_y;
    logic                    m_valid_y;
    logic                    m_ready_y;

    modport master (
        output s_data_in_w, s_valid_w,
        input  s_ready_w,
        output s_data_in_x, s_valid_x,
        input  s_ready_x,
        input  m_data_out_y, m_valid_y,
        output m_ready_y
    );

    modport slave (
        input  s_data_in_w, s_valid_w,
        output s_ready_w,
        input  s_data_in_x, s_valid_x,
        output s_ready_x,
        output m_data_out_y, m_valid_y,
        input  m_ready_y
    );
endinterface

// File: rtl/layer_fc_param.sv
// Fully-connected layer y = f(W*x) with P parallel MAC lanes, runtime-loaded weights,
// signed saturation and optional ReLU; one output group of P rows is computed at a time.
module layer_fc_param #(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int P     = 2,
    parameter int WIDTH = 16,
    parameter int RELU  = 1
) (
    input logic             clk,
    input logic             reset,
    layer_fc_param_if.slave bus
);
    localparam int G     = N / P;
    localparam int DEPTH = G * M;
    localparam int AD    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XA    = $clog2(M);
    localparam int LW    = (P > 1) ? $clog2(P) : 1;
    localparam int AW    = 2 * WIDTH + $clog2(M);
    localparam int CW    = $clog2(M * N + 4) + 1;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] M_C    = CW'(M);
    localparam logic [CW-1:0] M_LAST = CW'(M - 1);
    localparam logic [CW-1:0] C_LAST = CW'(M + 1);
    localparam logic [CW-1:0] P_LAST = CW'(P - 1);
    localparam logic [CW-1:0] G_LAST = CW'(G - 1);

    localparam logic signed [AW-1:0] SAT_HI = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] a);
        if (a > SAT_HI)      return SAT_HI[WIDTH-1:0];
        else if (a < SAT_LO) return SAT_LO[WIDTH-1:0];
        else                 return a[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] act(input logic signed [WIDTH-1:0] v);
        if (RELU != 0 && v[WIDTH-1]) return '0;
        return v;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_COMPUTE, S_OUTPUT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] wm, wlane, wgrp, xcnt, ccnt, grp, olane;
    logic          ready_w, ready_x, valid_y;
    logic          w_fire, x_fire, y_fire, w_last, c_done, rd_en, res_load;
    logic          vld_p0, first_p0;
    logic [AD-1:0] waddr, raddr;
    logic [XA-1:0] xaddr_w, xaddr_r;
    logic [LW-1:0] olane_idx;

    assign w_fire   = bus.s_valid_w && ready_w;
    assign x_fire   = bus.s_valid_x && ready_x;
    assign y_fire   = valid_y && bus.m_ready_y;
    assign w_last   = (wm == M_LAST) && (wlane == P_LAST) && (wgrp == G_LAST);
    assign c_done   = (ccnt == C_LAST);
    assign rd_en    = (state == S_COMPUTE) && (ccnt < M_C);
    assign res_load = (state == S_COMPUTE) && c_done;

    // Row n of W lives in bank n%P at (n/P)*M+m; compute reads row grp*P+lane at grp*M+m.
    assign waddr     = AD'(wgrp * M_C + wm);
    assign raddr     = AD'(grp * M_C + ccnt);
    assign xaddr_w   = XA'(xcnt);
    assign xaddr_r   = XA'(ccnt);
    assign olane_idx = LW'(olane);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_w   = 1'b0;
        ready_x   = 1'b0;
        valid_y   = 1'b0;
        case (state)
            S_IDLE:    state_nxt = S_LOAD_W;
            S_LOAD_W: begin
                ready_w = 1'b1;
                if (bus.s_valid_w && w_last) state_nxt = S_LOAD_X;
            end
            S_LOAD_X: begin
                ready_x = 1'b1;
                if (bus.s_valid_x && xcnt == M_LAST) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: if (c_done) state_nxt = S_OUTPUT;
            S_OUTPUT: begin
                valid_y = 1'b1;
                if (bus.m_ready_y && olane == P_LAST)
                    state_nxt = (grp == G_LAST) ? S_LOAD_X : S_COMPUTE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wm       <= '0;
            wlane    <= '0;
            wgrp     <= '0;
            xcnt     <= '0;
            ccnt     <= '0;
            grp      <= '0;
            olane    <= '0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
        end else begin
            vld_p0   <= rd_en;
            first_p0 <= (ccnt == '0);
            if (w_fire) begin
                if (wm == M_LAST) begin
                    wm <= '0;
                    if (wlane == P_LAST) begin
                        wlane <= '0;
                        wgrp  <= wgrp + ONE;
                    end else begin
                        wlane <= wlane + ONE;
                    end
                end else begin
                    wm <= wm + ONE;
                end
            end
            if (x_fire) xcnt <= (xcnt == M_LAST) ? '0 : xcnt + ONE;
            if (state == S_LOAD_X) begin
                grp  <= '0;
                ccnt <= '0;
            end
            if (state == S_COMPUTE) begin
                ccnt <= c_done ? '0 : ccnt + ONE;
                if (c_done) olane <= '0;
            end
            if (y_fire) begin
                if (olane == P_LAST) begin
                    olane <= '0;
                    grp   <= grp + ONE;
                end else begin
                    olane <= olane + ONE;
                end
            end
        end
    end

    logic signed [WIDTH-1:0] xmem [M];
    logic signed [WIDTH-1:0] x_p0;

    // p0: registered read of x[m] and each lane's weight
    always_ff @(posedge clk) begin
        if (x_fire) xmem[xaddr_w] <= bus.s_data_in_x;
        if (rd_en)  x_p0 <= xmem[xaddr_r];
    end

    logic signed [WIDTH-1:0] lane_y [P];

    for (genvar l = 0; l < P; l++) begin : g_lane
        logic signed [WIDTH-1:0]   bank [DEPTH];
        logic signed [WIDTH-1:0]   w_p0;
        logic signed [2*WIDTH-1:0] prod;
        logic signed [AW-1:0]      prod_ext;
        logic signed [AW-1:0]      acc_p1;
        logic signed [WIDTH-1:0]   y_p2;

        assign prod     = (2*WIDTH)'(x_p0) * (2*WIDTH)'(w_p0);
        assign prod_ext = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};

        always_ff @(posedge clk) begin
            if (w_fire && wlane == CW'(l)) bank[waddr] <= bus.s_data_in_w;
            if (rd_en) w_p0 <= bank[raddr];
        end

        // p1: accumulate; p2: saturate/activate into the output holding register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc_p1 <= '0;
                y_p2   <= '0;
            end else begin
                if (vld_p0)   acc_p1 <= first_p0 ? prod_ext : acc_p1 + prod_ext;
                if (res_load) y_p2   <= act(sat(acc_p1));
            end
        end

        assign lane_y[l] = y_p2;
    end

    assign bus.s_ready_w    = ready_w;
    assign bus.s_ready_x    = ready_x;
    assign bus.m_valid_y    = valid_y;
    assign bus.m_data_out_y = lane_y[olane_idx];
endmodule

// File: tb/tb_layer_fc_param.sv
// Bench for layer_fc_param: two instances (ReLU and linear) share one stimulus stream and
// are compared against an arithmetic reference of y = f(sat(W*x)).
module tb_layer_fc_param;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int P     = 2;
    localparam int WIDTH = 16;
    localparam int LAT   = M + 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int W [N][M];
    int xq[$];
    int exp0[$];
    int exp1[$];

    layer_fc_param_if #(.WIDTH(WIDTH)) bus0 ();
    layer_fc_param_if #(.WIDTH(WIDTH)) bus1 ();

    layer_fc_param #(.M(M), .N(N), .P(P), .WIDTH(WIDTH), .RELU(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    layer_fc_param #(.M(M), .N(N), .P(P), .WIDTH(WIDTH), .RELU(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    assign bus1.s_data_in_w = bus0.s_data_in_w;
    assign bus1.s_valid_w   = bus0.s_valid_w;
    assign bus1.s_data_in_x = bus0.s_data_in_x;
    assign bus1.s_valid_x   = bus0.s_valid_x;
    assign bus1.m_ready_y   = bus0.m_ready_y;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_y(input int n, input int xv[M], input bit relu);
        longint s = 0;
        for (int m = 0; m < M; m++) s += longint'(W[n][m]) * longint'(xv[m]);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    function automatic int rnd_val();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(3) == 0) return int'($signed(r));
        return int'($urandom_range(128)) - 64;
    endfunction

    task automatic set_w(input int mode);
        for (int n = 0; n < N; n++)
            for (int m = 0; m < M; m++)
                case (mode)
                    0: W[n][m] = (n == m) ? 1 : 0;
                    1: W[n][m] = 32767;
                    2: W[n][m] = -32768;
                    3: W[n][m] = n + m + 1;
                    default: W[n][m] = rnd_val();
                endcase
    endtask

    task automatic rand_vec(output int xv[M]);
        for (int m = 0; m < M; m++) xv[m] = rnd_val();
    endtask

    task automatic push_vec(input int xv[M]);
        for (int m = 0; m < M; m++) xq.push_back(xv[m]);
        for (int n = 0; n < N; n++) begin
            exp0.push_back(ref_y(n, xv, 1'b1));
            exp1.push_back(ref_y(n, xv, 1'b0));
        end
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_rst_rdy_w"}, longint'(bus0.s_ready_w), 0);
        chk({tag, "_rst_rdy_x"}, longint'(bus0.s_ready_x), 0);
        chk({tag, "_rst_vld_y"}, longint'(bus0.m_valid_y), 0);
        chk({tag, "_rst_dat_y"}, longint'($signed(bus0.m_data_out_y)), 0);
        chk({tag, "_rst_vld_y1"}, longint'(bus1.m_valid_y), 0);
        bus0.s_valid_w = 1'b0;
        bus0.s_valid_x = 1'b0;
        bus0.m_ready_y = 1'b0;
        xq.delete();
        exp0.delete();
        exp1.delete();
        repeat (2) @(negedge clk);
        chk({tag, "_hold_rdy_w"}, longint'(bus0.s_ready_w), 0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk({tag, "_rel_rdy_w"}, longint'(bus0.s_ready_w), 1);
        chk({tag, "_rel_rdy_x"}, longint'(bus0.s_ready_x), 0);
    endtask

    task automatic load_weights(input int gap_pct, input string tag);
        int idx = 0;
        int budget = 0;
        while (idx < M * N && budget < 2000) begin
            @(negedge clk);
            budget++;
            bus0.s_valid_w   = ($urandom_range(99) >= gap_pct);
            bus0.s_data_in_w = WIDTH'(W[idx / M][idx % M]);
            if (bus0.s_valid_w && bus0.s_ready_w) idx++;
        end
        @(negedge clk);
        bus0.s_valid_w = 1'b0;
        chk({tag, "_wcount"}, idx, M * N);
    endtask

    task automatic run_stream(input int rdy_pct, input int gap_pct, input int stop_after,
                              input bit junk_w, input string tag);
        int nx = xq.size();
        int limit = (stop_after >= 0) ? stop_after : exp0.size();
        int xi = 0, got = 0, pend = 0, budget = 0, last_ev = -1;
        int v_stab = 0, v_rdx = 0, v_lat = 0, v_sync = 0;
        bit prev_v = 1'b0, stall = 1'b0, want_rdx = 1'b0;
        logic signed [WIDTH-1:0] hold_d = '0;
        while (got < limit && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (stall && (!bus0.m_valid_y || bus0.m_data_out_y !== hold_d)) v_stab++;
            if (bus0.m_valid_y && !prev_v && last_ev >= 0 && cyc - last_ev != LAT) v_lat++;
            if (bus0.m_valid_y !== bus1.m_valid_y) v_sync++;
            if (pend > 0 && bus0.s_ready_x) v_rdx++;
            if (want_rdx) begin
                if (!bus0.s_ready_x) v_rdx++;
                want_rdx = 1'b0;
            end
            bus0.m_ready_y   = ($urandom_range(99) < rdy_pct);
            bus0.s_valid_x   = (xi < nx) && ($urandom_range(99) >= gap_pct);
            bus0.s_data_in_x = (xi < nx) ? WIDTH'(xq[xi]) : '0;
            if (junk_w) begin
                bus0.s_valid_w   = 1'($urandom_range(1));
                bus0.s_data_in_w = WIDTH'($urandom);
            end
            if (bus0.s_valid_x && bus0.s_ready_x) begin
                xi++;
                if (xi % M == 0) begin
                    pend += N;
                    last_ev = cyc + 1;
                end
            end
            if (bus0.m_valid_y && bus0.m_ready_y) begin
                chk({tag, "_y_relu"}, longint'($signed(bus0.m_data_out_y)), exp0.pop_front());
                chk({tag, "_y_lin"}, longint'($signed(bus1.m_data_out_y)), exp1.pop_front());
                got++;
                pend--;
                if (pend == 0) want_rdx = 1'b1;
                else if (pend % P == 0) last_ev = cyc + 1;
                stall = 1'b0;
            end else begin
                stall = bus0.m_valid_y;
            end
            hold_d = bus0.m_data_out_y;
            prev_v = bus0.m_valid_y;
        end
        chk({tag, "_outputs"}, got, limit);
        @(negedge clk);
        bus0.s_valid_x = 1'b0;
        bus0.s_valid_w = 1'b0;
        bus0.m_ready_y = 1'b0;
        if (stop_after < 0) begin
            chk({tag, "_rdx_rise"}, longint'(bus0.s_ready_x), 1);
            chk({tag, "_stable"}, v_stab, 0);
            chk({tag, "_rdx_excl"}, v_rdx, 0);
            chk({tag, "_latency"}, v_lat, 0);
            chk({tag, "_lockstep"}, v_sync, 0);
        end
        xq.delete();
    endtask

    initial begin
        int v[M];
        bus0.s_data_in_w = '0;
        bus0.s_valid_w   = 1'b0;
        bus0.s_data_in_x = '0;
        bus0.s_valid_x   = 1'b0;
        bus0.m_ready_y   = 1'b0;

        reset_pulse("por");

        set_w(0);
        load_weights(0, "ident");
        v = '{3, -5, 7, 2};
        push_vec(v);
        run_stream(100, 0, -1, 1'b0, "ident");

        reset_pulse("sat_p");
        set_w(1);
        load_weights(0, "sat_p");
        v = '{32767, 32767, 32767, 32767};
        push_vec(v);
        run_stream(100, 0, -1, 1'b0, "sat_p");

        reset_pulse("sat_n");
        set_w(2);
        load_weights(0, "sat_n");
        push_vec(v);
        run_stream(100, 0, -1, 1'b0, "sat_n");

        reset_pulse("mac");
        set_w(3);
        load_weights(30, "mac");
        v = '{1, 2, 3, 4};
        push_vec(v);
        run_stream(100, 0, -1, 1'b0, "mac");

        for (int k = 0; k < 4; k++) begin
            rand_vec(v);
            push_vec(v);
        end
        run_stream(50, 30, -1, 1'b1, "bp");

        for (int k = 0; k < 3; k++) begin
            rand_vec(v);
            push_vec(v);
        end
        run_stream(100, 0, -1, 1'b0, "b2b");

        rand_vec(v);
        push_vec(v);
        run_stream(100, 0, 2, 1'b0, "abort_c");
        reset_pulse("rst_comp");

        set_w(4);
        load_weights(0, "rw1");
        @(negedge clk);
        chk("ldx_rdy_x", longint'(bus0.s_ready_x), 1);
        reset_pulse("rst_ldx");

        set_w(4);
        load_weights(20, "rw2");
        rand_vec(v);
        push_vec(v);
        run_stream(100, 0, 1, 1'b0, "abort_o");
        @(negedge clk);
        chk("pre_rst_vld", longint'(bus0.m_valid_y), 1);
        reset_pulse("rst_out");

        set_w(4);
        load_weights(0, "rw3");
        for (int k = 0; k < 2; k++) begin
            rand_vec(v);
            push_vec(v);
        end
        run_stream(70, 20, -1, 1'b1, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/layer_fc_param.md
# layer_fc_param

Parametrised fully-connected layer engine for the MLP datapath: computes y = f(W·x) for an M-input, N-output layer using P parallel MAC lanes, with signed saturation and selectable ReLU. Unlike the fixed per-layer blocks, weights are loaded at runtime over a dedicated stream after reset, and M, N, P, WIDTH and activation are all parameters. It drops into the layer chain with the same x/y valid/ready stream handshake, so multi-layer tops are built by chaining instances.

## Interface
- M, 8, input vector length (≥2)
- N, 8, output vector length; N % P == 0 required
- P, 2, parallel MAC lanes / weight banks
- WIDTH, 16, signed data/weight width
- RELU, 1, 1 = clamp negative outputs to 0; 0 = linear
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- s_data_in_w  in  WIDTH  weight stream data, signed
- s_valid_w  in  1  weight valid
- s_ready_w  out  1  weight ready
- s_data_in_x  in  WIDTH  input vector element, signed
- s_valid_x  in  1  input valid
- s_ready_x  out  1  input ready
- m_data_out_y  out  WIDTH  output element, signed
- m_valid_y  out  1  output valid
- m_ready_y  in  1  downstream ready

## Operation
- Transfer on any stream = valid && ready at a rising edge.
- FSM states: LOAD_W -> LOAD_X -> COMPUTE -> OUTPUT -> (COMPUTE for next group | LOAD_X after last group).
- LOAD_W: s_ready_w=1; accepts exactly M*N weights, row-major W[n][m], m fastest. Row n stored in bank n%P at address (n/P)*M+m. After last weight -> LOAD_X. Weights reloadable only via reset.
- LOAD_X: s_ready_x=1; accepts M elements x[0..M-1] into x memory. After M-th -> COMPUTE, group g=0.
- COMPUTE (group g, rows g*P..g*P+P-1): each lane clears accumulator, reads x[m] and its bank weight for m=0..M-1, accumulates x*W; 1-cycle memory read + 1-cycle MAC register.
- Arithmetic: product 2*WIDTH signed; accumulator 2*WIDTH+clog2(M) bits, no wrap. Result saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then ReLU if RELU=1.
- OUTPUT: emits lanes 0..P-1 in order (y[g*P] first). After lane P-1 transfers: g<N/P-1 -> COMPUTE g+1; else -> LOAD_X.
- Output order overall: y[0]..y[N-1].
- s_valid_w ignored outside LOAD_W; s_valid_x ignored outside LOAD_X.

## Timing
- Reset values: s_ready_w=0 while reset low, 1 from first cycle after release (state LOAD_W); s_ready_x=0, m_valid_y=0, m_data_out_y=0; accumulators, counters cleared.
- Reset asserted mid-operation (any state): outputs return to reset values asynchronously; in-flight vector discarded; block requires full weight reload.
- COMPUTE length exactly M+2 cycles; m_valid_y rises exactly M+2 cycles after the edge accepting the last x of a vector (group 0), and M+2 cycles after the edge transferring lane P-1 of the previous group.
- With m_ready_y held 1, each group's P outputs transfer on P consecutive cycles.
- m_valid_y && !m_ready_y: m_data_out_y and m_valid_y held stable until transfer; never deasserted without transfer.
- s_ready_x rises the cycle after the final y transfer; no overlap of input load with compute/output.
- Total per-vector throughput with no stalls: M + (N/P)*(M+2+P) cycles.

## Test plan
- Identity, M=N=4, P=2, RELU=1: W=I, x=[3,-5,7,2] -> y=[3,0,7,2]; RELU=0 -> y=[3,-5,7,2].
- Saturation, M=N=4, P=2, RELU=0: all W=32767, all x=32767 -> every y=32767; all W=-32768, x=32767 -> every y=-32768 (RELU=1 -> 0).
- General MAC: W[n][m]=n+m+1, x=[1,2,3,4] -> y=[30,40,50,60]; check first m_valid_y exactly 6 cycles after last x edge.
- Backpressure: m_ready_y random 50% -> same y sequence, data stable during stall, no drops/dups; s_valid_x/s_valid_w gaps tolerated.
- Reset mid-COMPUTE: drive reset low during group 1 -> m_valid_y=0, s_ready_x=0 immediately; after release s_ready_w=1; reload W, new x -> correct y.
- Back-to-back: three vectors streamed with s_valid_x held 1 -> 12 outputs in order, s_ready_x low from vector accept until last y transfer.
